perm_unload: RTL and testbench

Streams the 25-lane (5x5x64) Keccak state out of a state memory after a permutation completes. It is the transmit end of the lane protocol that perm_blk receives on (pushin/stopin/firstin/din). It sits between the state memory read port and the downstream consumer (next perm stage, squeeze logic or testbench sink). It emits lanes in x-fastest order on pushout/stopout/firstout/dout, with full throughput and backpressure.

---
 rtl/perm_unload.sv | 126 ++++++++++++
 tb/tb_perm_unload.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perm_unload.sv
// perm_unload: streams the 5x5x64 Keccak state out of state memory, x-fastest, with backpressure.
// Define PERM_UNLOAD_RATE_EN to emit only the first RATE_LANES lanes instead of all 25.
module perm_unload #(
    parameter int unsigned RATE_LANES = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  mrx_o,
    output logic [2:0]  mry_o,
    input  logic [63:0] mrd_i,
    output logic        pushout_o,
    input  logic        stopout_i,
    output logic        firstout_o,
    output logic        lastout_o,
    output logic [63:0] dout_o
);

    if (RATE_LANES < 1 || RATE_LANES > 25) begin : g_rate_check
        $error("RATE_LANES must be in 1..25");
    end

`ifdef PERM_UNLOAD_RATE_EN
    localparam int unsigned NumLanes = RATE_LANES;
`else
    localparam int unsigned NumLanes = 25;
`endif
    localparam logic [4:0] LastIdx = 5'(NumLanes - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e      state_q;
    logic [2:0]  x_q;
    logic [2:0]  y_q;
    logic        busy_q;
    logic        done_q;
    logic        pushout_q;
    logic        firstout_q;
    logic        lastout_q;
    logic [63:0] dout_q;

    logic [4:0]  lane_idx;
    logic        load;
    logic        is_last;

    assign lane_idx = {2'b00, x_q} + 5'd5 * {2'b00, y_q};
    assign is_last  = (lane_idx == LastIdx);
    // The output register refills whenever it is empty or being drained this cycle.
    assign load     = (state_q == StStream) && (!pushout_q || !stopout_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            x_q        <= 3'd0;
            y_q        <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pushout_q  <= 1'b0;
            firstout_q <= 1'b0;
            lastout_q  <= 1'b0;
            dout_q     <= 64'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StStream;
                        busy_q  <= 1'b1;
                    end
                end
                StStream: begin
                    if (load) begin
                        dout_q     <= mrd_i;
                        firstout_q <= (lane_idx == 5'd0);
                        lastout_q  <= is_last;
                        pushout_q  <= 1'b1;
                        if (is_last) begin
                            // Park the pointer so it never addresses lanes past the last one.
                            x_q     <= 3'd0;
                            y_q     <= 3'd0;
                            state_q <= StDrain;
                        end else if (x_q == 3'd4) begin
                            x_q <= 3'd0;
                            y_q <= y_q + 3'd1;
                        end else begin
                            x_q <= x_q + 3'd1;
                        end
                    end
                end
                StDrain: begin
                    if (pushout_q && !stopout_i) begin
                        pushout_q  <= 1'b0;
                        firstout_q <= 1'b0;
                        lastout_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign mrx_o      = x_q;
    assign mry_o      = y_q;
    assign pushout_o  = pushout_q;
    assign firstout_o = firstout_q;
    assign lastout_o  = lastout_q;
    assign dout_o     = dout_q;

endmodule

// File: tb/tb_perm_unload.sv
// Scoreboard bench for perm_unload: stimulus queues expected lanes, a monitor pops on each transfer.
module tb_perm_unload;

`ifdef PERM_UNLOAD_RATE_EN
    localparam int N = 17;
`else
    localparam int N = 25;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic [2:0]  mrx_o;
    logic [2:0]  mry_o;
    logic [63:0] mrd_i;
    logic        pushout_o;
    logic        stopout_i;
    logic        firstout_o;
    logic        lastout_o;
    logic [63:0] dout_o;

    perm_unload #(
        .RATE_LANES(17)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .mrx_o     (mrx_o),
        .mry_o     (mry_o),
        .mrd_i     (mrd_i),
        .pushout_o (pushout_o),
        .stopout_i (stopout_i),
        .firstout_o(firstout_o),
        .lastout_o (lastout_o),
        .dout_o    (dout_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic        f;
        logic        l;
    } lane_t;

    lane_t exp_q[$];
    int    n_pass   = 0;
    int    n_chk    = 0;
    int    xfer_cnt = 0;
    int    done_cnt = 0;

    // Memory image: lane(x,y) = 64'h0000_00XY_0000_00XY.
    function automatic logic [63:0] lane_val(input logic [2:0] x, input logic [2:0] y);
        return {24'h0, 1'b0, x, 1'b0, y, 24'h0, 1'b0, x, 1'b0, y};
    endfunction

    assign mrd_i = lane_val(mrx_o, mry_o);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_expected();
        lane_t e;
        for (int k = 0; k < N; k++) begin
            e.d = lane_val(3'(k % 5), 3'(k / 5));
            e.f = (k == 0);
            e.l = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    // Mode 1: stall cycles 5..9 then odd cycles 11..29 (15 stalls). Mode 3: stall cycles 0..9.
    function automatic logic stop_fn(input int mode, input int c);
        case (mode)
            1:       return (c >= 5 && c <= 9) || (c >= 11 && c <= 29 && (c % 2) == 1);
            3:       return (c <= 9);
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: pops the scoreboard on every transfer, checks stall hold and pointer range.
    initial begin
        logic        prev_stall;
        logic [63:0] prev_d;
        logic        prev_f;
        logic        prev_l;
        lane_t       e;
        prev_stall = 1'b0;
        prev_d     = 64'd0;
        prev_f     = 1'b0;
        prev_l     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (done_o) done_cnt++;
                if (busy_o)
                    chk("ptr_range",
                        {63'd0, (mrx_o < 3'd5 && mry_o < 3'd5 &&
                                 (int'(mrx_o) + 5 * int'(mry_o)) < N)}, 64'd1);
                if (prev_stall) begin
                    chk("stall_hold_dout", dout_o, prev_d);
                    chk("stall_hold_flags", {61'd0, pushout_o, firstout_o, lastout_o},
                        {61'd0, 1'b1, prev_f, prev_l});
                end
                if (pushout_o && stopout_i) begin
                    prev_stall = 1'b1;
                    prev_d     = dout_o;
                    prev_f     = firstout_o;
                    prev_l     = lastout_o;
                end else begin
                    prev_stall = 1'b0;
                end
                if (pushout_o && !stopout_i) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_xfer: got lane %h, expected no transfer", dout_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("lane_dout", dout_o, e.d);
                        chk("lane_flags", {62'd0, firstout_o, lastout_o}, {62'd0, e.f, e.l});
                    end
                end
            end
        end
    end

    // Cycle c is the period after the (c-1)th posedge following the start-sampling edge (cycle 0).
    task automatic run_unload(input int mode, input int exp_done, input string name);
        int rel;
        int d0;
        bit got;
        push_expected();
        d0 = done_cnt;
        @(posedge clk);
        #1;
        start_i   = 1'b1;
        stopout_i = stop_fn(mode, 0);
        @(posedge clk);
        rel = 1;
        #1;
        start_i   = 1'b0;
        stopout_i = stop_fn(mode, 1);
        got = 1'b0;
        while (!got && rel < 200) begin
            @(negedge clk);
            if (rel == 1)
                chk({name, "_c1_busy_ptr"}, {56'd0, busy_o, pushout_o, mrx_o, mry_o},
                    {56'd0, 1'b1, 1'b0, 3'd0, 3'd0});
            if (rel == 2) begin
                chk({name, "_c2_push_first"}, {62'd0, pushout_o, firstout_o}, 64'd3);
                chk({name, "_c2_dout"}, dout_o, 64'h0);
            end
            if (done_o) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                rel++;
                #1;
                stopout_i = stop_fn(mode, rel);
                start_i   = (mode == 2 && rel == 5);
            end
        end
        chk({name, "_done_cycle"}, 64'(rel), 64'(exp_done));
        stopout_i = 1'b0;
        start_i   = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({name, "_lanes_left"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_idle_busy"}, {63'd0, busy_o}, 64'd0);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_ctl"}, {53'd0, pushout_o, firstout_o, lastout_o, busy_o, done_o, mrx_o, mry_o},
            64'd0);
        chk({name, "_dout"}, dout_o, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int cnt;
        rst       = 1'b1;
        start_i   = 1'b0;
        stopout_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset_state");
        rst = 1'b0;

        run_unload(0, N + 2, "full");
        run_unload(1, N + 17, "backpressure");
        run_unload(2, N + 2, "ignored_start");
        run_unload(3, N + 10, "stop_pre");

        // Abort after lane 10 is accepted, then restart from (0,0).
        push_expected();
        @(posedge clk);
        #1;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        x0  = xfer_cnt;
        cnt = 0;
        while (xfer_cnt < x0 + 11 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("rst_reach_lane10", 64'(xfer_cnt - x0), 64'd11);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        exp_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        run_unload(0, N + 2, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
